// File: rtl/jelly3_sum_tree_acc.sv
// rtl/jelly3_sum_tree_acc.sv - pipelined masked adder tree with per-frame accumulator
// Reduces N enable-masked elements per beat and accumulates beat sums from s_first to s_last.
module jelly3_sum_tree_acc #(
  parameter int N           = 16,
  parameter int UNIT        = 2,
  parameter int SIGNED      = 1,
  parameter int SATURATE    = 1,
  parameter int S_DATA_BITS = 8,
  parameter int M_DATA_BITS = S_DATA_BITS + $clog2(N) + 8,
  parameter int USER_BITS   = 1,
  parameter int COUNT_BITS  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cke,
  input  logic [N-1:0]             s_en,
  input  logic [N*S_DATA_BITS-1:0] s_data,
  input  logic                     s_first,
  input  logic                     s_last,
  input  logic [USER_BITS-1:0]     s_user,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic [M_DATA_BITS-1:0]   m_data,
  output logic [COUNT_BITS-1:0]    m_count,
  output logic                     m_ovf,
  output logic [USER_BITS-1:0]     m_user,
  output logic                     m_valid,
  input  logic                     m_ready
);

  function automatic int calc_latency(int n, int unit);
    int lat;
    int cnt;
    lat = 0;
    cnt = n;
    while (cnt > 1) begin
      cnt = (cnt + unit - 1) / unit;
      lat++;
    end
    return lat;
  endfunction

  localparam int  LATENCY   = calc_latency(N, UNIT);
  localparam int  T_BITS    = S_DATA_BITS + $clog2(N);
  localparam int  W_BITS    = M_DATA_BITS + 1;
  localparam bit  IS_SIGNED = (SIGNED != 0);
  localparam bit  IS_SAT    = (SATURATE != 0);
  localparam logic [M_DATA_BITS-1:0] MAX_VAL =
      IS_SIGNED ? {1'b0, {(M_DATA_BITS-1){1'b1}}} : {M_DATA_BITS{1'b1}};
  localparam logic [M_DATA_BITS-1:0] MIN_VAL =
      IS_SIGNED ? {1'b1, {(M_DATA_BITS-1){1'b0}}} : {M_DATA_BITS{1'b0}};

  logic advance;

  assign advance = cke && (!m_valid || m_ready);
  assign s_ready = advance;

  // Level 0 is the masked, extended input; levels 1..LATENCY are registered partial sums.
  for (genvar k = 0; k <= LATENCY; k++) begin : g_lvl
    logic [T_BITS-1:0]    sum [N];
    logic                 valid;
    logic                 first;
    logic                 last;
    logic [USER_BITS-1:0] user;

    if (k == 0) begin : g_in
      always_comb begin
        for (int i = 0; i < N; i++) begin
          sum[i] = '0;
          if (s_en[i]) begin
            sum[i] = IS_SIGNED ? T_BITS'($signed(s_data[i*S_DATA_BITS +: S_DATA_BITS]))
                               : T_BITS'(s_data[i*S_DATA_BITS +: S_DATA_BITS]);
          end
        end
      end
      assign valid = s_valid;
      assign first = s_first;
      assign last  = s_last;
      assign user  = s_user;
    end else begin : g_reg
      logic [T_BITS-1:0] nxt [N];

      // Node j folds operands j*UNIT .. j*UNIT+UNIT-1; slots past the previous level are zero.
      always_comb begin
        for (int j = 0; j < N; j++) begin
          nxt[j] = '0;
          for (int u = 0; (u < UNIT) && (j*UNIT + u < N); u++) begin
            nxt[j] = nxt[j] + g_lvl[k-1].sum[j*UNIT + u];
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid <= 1'b0;
          first <= 1'b0;
          last  <= 1'b0;
          user  <= '0;
          for (int j = 0; j < N; j++) sum[j] <= '0;
        end else if (advance) begin
          valid <= g_lvl[k-1].valid;
          first <= g_lvl[k-1].first;
          last  <= g_lvl[k-1].last;
          user  <= g_lvl[k-1].user;
          for (int j = 0; j < N; j++) sum[j] <= nxt[j];
        end
      end
    end
  end

  logic [T_BITS-1:0]      top_sum;
  logic                   top_valid;
  logic                   top_first;
  logic                   top_last;
  logic [USER_BITS-1:0]   top_user;

  assign top_sum   = g_lvl[LATENCY].sum[0];
  assign top_valid = g_lvl[LATENCY].valid;
  assign top_first = g_lvl[LATENCY].first;
  assign top_last  = g_lvl[LATENCY].last;
  assign top_user  = g_lvl[LATENCY].user;

  logic [M_DATA_BITS-1:0] acc;
  logic [M_DATA_BITS-1:0] acc_next;
  logic [COUNT_BITS-1:0]  cnt;
  logic [COUNT_BITS-1:0]  cnt_next;
  logic                   ovf_acc;
  logic                   ovf_next;
  logic                   ovf;
  logic [W_BITS-1:0]      base_w;
  logic [W_BITS-1:0]      sum_w;
  logic [W_BITS-1:0]      wide;

  // One guard bit above the accumulator width exposes overflow of base + beat sum.
  always_comb begin
    base_w = '0;
    if (!top_first) base_w = IS_SIGNED ? W_BITS'($signed(acc)) : W_BITS'(acc);
    sum_w    = IS_SIGNED ? W_BITS'($signed(top_sum)) : W_BITS'(top_sum);
    wide     = base_w + sum_w;
    ovf      = IS_SIGNED ? (wide[W_BITS-1] != wide[W_BITS-2]) : wide[W_BITS-1];
    acc_next = wide[M_DATA_BITS-1:0];
    if (ovf && IS_SAT) acc_next = (IS_SIGNED && wide[W_BITS-1]) ? MIN_VAL : MAX_VAL;
    ovf_next = (top_first ? 1'b0 : ovf_acc) | ovf;
    cnt_next = top_first ? COUNT_BITS'(1) : ((&cnt) ? cnt : cnt + 1'b1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      m_data  <= '0;
      m_count <= '0;
      m_ovf   <= 1'b0;
      m_user  <= '0;
      m_valid <= 1'b0;
    end else if (advance) begin
      m_valid <= top_valid && top_last;
      if (top_valid) begin
        if (top_last) begin
          m_data  <= acc_next;
          m_ovf   <= ovf_next;
          m_count <= cnt_next;
          m_user  <= top_user;
          // Cleared so a following frame without s_first still starts from zero.
          acc     <= '0;
          ovf_acc <= 1'b0;
          cnt     <= '0;
        end else begin
          acc     <= acc_next;
          ovf_acc <= ovf_next;
          cnt     <= cnt_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_jelly3_sum_tree_acc.sv
// tb/tb_jelly3_sum_tree_acc.sv - randomized bench with an integer frame-sum reference model
// Four configurations: default signed, 12-bit saturating, 12-bit wrapping, unsigned N=10 radix 4.
module tb_jelly3_sum_tree_acc;
  localparam int N  = 16;
  localparam int S  = 8;
  localparam int UB = 4;
  localparam int CB = 16;
  localparam int MA = S + $clog2(N) + 8;
  localparam int MB = 12;
  localparam int ND = 10;
  localparam int MD = S + $clog2(ND) + 8;

  typedef struct { longint data; longint count; longint ovf; longint user; } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, cke, m_ready;
  logic [N-1:0] s_en;  logic [N*S-1:0] s_data;  logic s_first, s_last, s_valid; logic [UB-1:0] s_user;
  logic [ND-1:0] d_en; logic [ND*S-1:0] d_data; logic d_first, d_last, d_valid; logic [UB-1:0] d_user;
  logic rdy_a, rdy_b, rdy_c, rdy_d;
  logic mv_a, mv_b, mv_c, mv_d;
  logic mo_a, mo_b, mo_c, mo_d;
  logic [CB-1:0] mc_a, mc_b, mc_c, mc_d;
  logic [UB-1:0] mu_a, mu_b, mu_c, mu_d;
  logic [MA-1:0] da;
  logic [MB-1:0] db, dc;
  logic [MD-1:0] dd;

  jelly3_sum_tree_acc #(.N(N), .UNIT(2), .SIGNED(1), .SATURATE(1), .S_DATA_BITS(S),
                        .M_DATA_BITS(MA), .USER_BITS(UB), .COUNT_BITS(CB)) u_a (
    .clk(clk), .reset(reset), .cke(cke), .s_en(s_en), .s_data(s_data), .s_first(s_first),
    .s_last(s_last), .s_user(s_user), .s_valid(s_valid), .s_ready(rdy_a), .m_data(da),
    .m_count(mc_a), .m_ovf(mo_a), .m_user(mu_a), .m_valid(mv_a), .m_ready(m_ready));

  jelly3_sum_tree_acc #(.N(N), .UNIT(2), .SIGNED(1), .SATURATE(1), .S_DATA_BITS(S),
                        .M_DATA_BITS(MB), .USER_BITS(UB), .COUNT_BITS(CB)) u_b (
    .clk(clk), .reset(reset), .cke(cke), .s_en(s_en), .s_data(s_data), .s_first(s_first),
    .s_last(s_last), .s_user(s_user), .s_valid(s_valid), .s_ready(rdy_b), .m_data(db),
    .m_count(mc_b), .m_ovf(mo_b), .m_user(mu_b), .m_valid(mv_b), .m_ready(m_ready));

  jelly3_sum_tree_acc #(.N(N), .UNIT(2), .SIGNED(1), .SATURATE(0), .S_DATA_BITS(S),
                        .M_DATA_BITS(MB), .USER_BITS(UB), .COUNT_BITS(CB)) u_c (
    .clk(clk), .reset(reset), .cke(cke), .s_en(s_en), .s_data(s_data), .s_first(s_first),
    .s_last(s_last), .s_user(s_user), .s_valid(s_valid), .s_ready(rdy_c), .m_data(dc),
    .m_count(mc_c), .m_ovf(mo_c), .m_user(mu_c), .m_valid(mv_c), .m_ready(m_ready));

  jelly3_sum_tree_acc #(.N(ND), .UNIT(4), .SIGNED(0), .SATURATE(1), .S_DATA_BITS(S),
                        .M_DATA_BITS(MD), .USER_BITS(UB), .COUNT_BITS(CB)) u_d (
    .clk(clk), .reset(reset), .cke(cke), .s_en(d_en), .s_data(d_data), .s_first(d_first),
    .s_last(d_last), .s_user(d_user), .s_valid(d_valid), .s_ready(rdy_d), .m_data(dd),
    .m_count(mc_d), .m_ovf(mo_d), .m_user(mu_d), .m_valid(mv_d), .m_ready(m_ready));

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: exact integer frame sum, clamped or wrapped into each instance's width.
  int     mbits [4] = '{MA, MB, MB, MD};
  bit     msgn  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit     msat  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  longint m_acc [4];
  longint m_cnt [4];
  bit     m_ovfa[4];
  res_t   q     [4][$];
  res_t   last_res [4];
  int     n_res [4];
  int     cons_first [4];
  int     cons_last  [4];

  int cyc = 0;
  bit accepted = 1'b0;
  bit lat_arm = 1'b0;
  int lat_t0 = -1;
  int lat_t1 = -1;
  int left = 0;

  task automatic model_reset();
    for (int id = 0; id < 4; id++) begin
      m_acc[id] = 0; m_cnt[id] = 0; m_ovfa[id] = 1'b0;
    end
  endtask

  task automatic model_beat(input int id, input longint bsum, input bit first, input bit last,
                            input logic [UB-1:0] user);
    longint hi, lo, w, mask;
    bit o;
    mask = (longint'(1) <<< mbits[id]) - 1;
    hi = msgn[id] ? (longint'(1) <<< (mbits[id]-1)) - 1 : mask;
    lo = msgn[id] ? -(longint'(1) <<< (mbits[id]-1)) : 0;
    w  = (first ? 0 : m_acc[id]) + bsum;
    o  = (w > hi) || (w < lo);
    if (o && msat[id]) w = (w > hi) ? hi : lo;
    else if (o) begin
      w = w & mask;
      if (w > hi) w = w - (mask + 1);
    end
    m_ovfa[id] = (first ? 1'b0 : m_ovfa[id]) | o;
    m_cnt[id]  = first ? 1 : ((m_cnt[id] == (1 << CB) - 1) ? m_cnt[id] : m_cnt[id] + 1);
    m_acc[id]  = w;
    if (last) begin
      q[id].push_back('{w & mask, m_cnt[id], longint'(m_ovfa[id]), longint'(user)});
      m_acc[id] = 0; m_cnt[id] = 0; m_ovfa[id] = 1'b0;
    end
  endtask

  function automatic longint sum_a();
    longint s = 0;
    for (int i = 0; i < N; i++) if (s_en[i]) s += longint'($signed(s_data[i*S +: S]));
    return s;
  endfunction

  function automatic longint sum_d();
    longint s = 0;
    for (int i = 0; i < ND; i++) if (d_en[i]) s += longint'(d_data[i*S +: S]);
    return s;
  endfunction

  task automatic observe(input int id, input logic v, input logic [63:0] d, input logic [CB-1:0] c,
                         input logic o, input logic [UB-1:0] u);
    res_t e;
    if (v !== 1'b1) return;
    if (q[id].size() == 0) begin
      check($sformatf("unexpected_result%0d", id), 1, 0);
      return;
    end
    e = q[id][0];
    check($sformatf("data%0d", id), d, e.data);
    check($sformatf("count%0d", id), 64'(c), e.count);
    check($sformatf("ovf%0d", id), 64'(o), e.ovf);
    check($sformatf("user%0d", id), 64'(u), e.user);
    if (m_ready && cke) begin
      last_res[id] = '{longint'(d), longint'(c), longint'(o), longint'(u)};
      n_res[id]++;
      if (cons_first[id] < 0) cons_first[id] = cyc;
      cons_last[id] = cyc;
      void'(q[id].pop_front());
    end
  endtask

  // Inputs are driven at the falling edge; everything is sampled 1 time unit later.
  task automatic cycle();
    #1;
    accepted = s_valid && rdy_a;
    if (accepted) begin
      for (int id = 0; id < 3; id++) model_beat(id, sum_a(), s_first, s_last, s_user);
      if (lat_arm && lat_t0 < 0) lat_t0 = cyc;
    end
    if (d_valid && rdy_d) begin
      model_beat(3, sum_d(), d_first, d_last, d_user);
      if (lat_arm && lat_t0 < 0) lat_t0 = cyc;
    end
    if (lat_t0 >= 0 && lat_t1 < 0 && (mv_a || mv_d)) lat_t1 = cyc;
    if (mv_a === 1'b1 && m_ready === 1'b0 && cke === 1'b1) check("stall_s_ready", 64'(rdy_a), 0);
    if (cke === 1'b0) check("cke_s_ready", 64'(rdy_a), 0);
    observe(0, mv_a, 64'(da), mc_a, mo_a, mu_a);
    observe(1, mv_b, 64'(db), mc_b, mo_b, mu_b);
    observe(2, mv_c, 64'(dc), mc_c, mo_c, mu_c);
    observe(3, mv_d, 64'(dd), mc_d, mo_d, mu_d);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    bit done;
    s_valid = 1'b0; d_valid = 1'b0; m_ready = 1'b1; cke = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cycle();
      done = (q[0].size() + q[1].size() + q[2].size() + q[3].size() == 0) &&
             !mv_a && !mv_b && !mv_c && !mv_d;
      if (done) break;
    end
    for (int id = 0; id < 4; id++) check($sformatf("drained%0d", id), 64'(q[id].size()), 0);
  endtask

  task automatic arm_latency();
    lat_arm = 1'b1; lat_t0 = -1; lat_t1 = -1;
  endtask

  task automatic set_beat(input logic [N*S-1:0] data, input bit first, input bit last);
    s_en = '1; s_data = data; s_first = first; s_last = last; s_user = UB'($urandom); s_valid = 1'b1;
  endtask

  task automatic new_beat();
    s_en   = N'($urandom);
    s_data = {$urandom, $urandom, $urandom, $urandom};
    s_user = UB'($urandom);
    if (left == 0) begin
      left    = $urandom_range(1, 4);
      s_first = ($urandom_range(0, 9) != 0);
    end else begin
      s_first = 1'b0;
    end
    s_last = (left == 1);
    left--;
  endtask

  task automatic random_run(input int cycles, input bit noisy);
    for (int t = 0; t < cycles; t++) begin
      if (!s_valid || accepted) begin
        if ($urandom_range(0, 4) != 0) begin
          new_beat();
          s_valid = 1'b1;
        end else begin
          s_valid = 1'b0;
        end
      end
      if (noisy) begin
        m_ready = ($urandom_range(0, 3) != 0);
        cke     = ($urandom_range(0, 9) != 0);
      end else begin
        m_ready = !(t >= 100 && t < 110);
        cke     = 1'b1;
      end
      cycle();
    end
  endtask

  logic [N*S-1:0] pat;
  int base_n;

  initial begin
    reset = 1'b0; cke = 1'b0; m_ready = 1'b1;
    s_en = '0; s_data = '0; s_first = 1'b0; s_last = 1'b0; s_user = '0; s_valid = 1'b0;
    d_en = '0; d_data = '0; d_first = 1'b0; d_last = 1'b0; d_user = '0; d_valid = 1'b0;
    model_reset();
    for (int id = 0; id < 4; id++) begin
      n_res[id] = 0; cons_first[id] = -1; cons_last[id] = -1;
    end
    repeat (2) @(negedge clk);
    #1;
    check("rst_m_valid", 64'(mv_a), 0);
    check("rst_m_data", 64'(da), 0);
    check("rst_m_count", 64'(mc_a), 0);
    check("rst_m_ovf", 64'(mo_a), 0);
    check("rst_m_user", 64'(mu_a), 0);
    check("rst_cke0_s_ready", 64'(rdy_a), 0);
    @(negedge clk);
    reset = 1'b1; cke = 1'b1;
    cycle();

    // Continuous single-beat frames of 0..15.
    for (int i = 0; i < N; i++) pat[i*S +: S] = S'(i);
    arm_latency();
    for (int b = 0; b < 8; b++) begin
      set_beat(pat, 1'b1, 1'b1);
      cycle();
    end
    drain();
    lat_arm = 1'b0;
    check("latency_a", 64'(lat_t1 - lat_t0), 5);
    check("ramp_data", 64'(last_res[0].data), 120);
    check("ramp_count", 64'(last_res[0].count), 1);
    check("ramp_results", 64'(n_res[0]), 8);
    check("ramp_back_to_back", 64'(cons_last[0] - cons_first[0]), 7);

    // Three beats of -128 in every element.
    pat = {N{8'h80}};
    for (int b = 0; b < 3; b++) begin
      set_beat(pat, b == 0, b == 2);
      cycle();
    end
    drain();
    check("neg_data", 64'(last_res[0].data), 64'((longint'(-6144)) & ((longint'(1) <<< MA) - 1)));
    check("neg_count", 64'(last_res[0].count), 3);
    check("neg_ovf", 64'(last_res[0].ovf), 0);

    // Random enables on three-beat frames.
    for (int f = 0; f < 4; f++) begin
      for (int b = 0; b < 3; b++) begin
        set_beat({$urandom, $urandom, $urandom, $urandom}, b == 0, b == 2);
        s_en = N'($urandom);
        cycle();
      end
    end
    drain();

    // Two beats of +2032 overflow the 12-bit instances.
    pat = {N{8'd127}};
    for (int b = 0; b < 2; b++) begin
      set_beat(pat, b == 0, b == 1);
      cycle();
    end
    drain();
    check("sat_data", 64'(last_res[1].data), 2047);
    check("sat_ovf", 64'(last_res[1].ovf), 1);
    check("wrap_data", 64'(last_res[2].data), 64'hFE0);
    check("wrap_ovf", 64'(last_res[2].ovf), 1);
    pat = {N{8'd1}};
    set_beat(pat, 1'b1, 1'b1);
    cycle();
    drain();
    check("sat_next_ovf", 64'(last_res[1].ovf), 0);
    check("wrap_next_data", 64'(last_res[2].data), 16);

    // Random stream with a 10-cycle m_ready hole, then with random m_ready and cke.
    random_run(300, 1'b0);
    drain();
    random_run(400, 1'b1);
    drain();

    // Reset in the middle of a 4-beat frame.
    pat = {N{8'd5}};
    for (int b = 0; b < 2; b++) begin
      set_beat(pat, b == 0, 1'b0);
      cycle();
    end
    s_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    left = 0;
    cycle();
    check("midrst_m_valid", 64'(mv_a), 0);
    cycle();
    reset = 1'b1;
    cycle();
    base_n = n_res[0];
    pat = {N{8'd1}};
    set_beat(pat, 1'b1, 1'b1);
    cycle();
    drain();
    check("rst_frame_results", 64'(n_res[0] - base_n), 1);
    check("rst_frame_data", 64'(last_res[0].data), 16);
    check("rst_frame_count", 64'(last_res[0].count), 1);

    // Unsigned N=10, radix 4.
    arm_latency();
    d_en = '1; d_data = {ND{8'hFF}}; d_first = 1'b1; d_last = 1'b1; d_user = 4'h9; d_valid = 1'b1;
    cycle();
    drain();
    lat_arm = 1'b0;
    check("latency_d", 64'(lat_t1 - lat_t0), 3);
    check("d_data", 64'(last_res[3].data), 2550);
    check("d_user", 64'(last_res[3].user), 9);
    d_en = '0; d_valid = 1'b1;
    cycle();
    drain();
    check("d_masked_data", 64'(last_res[3].data), 0);
    check("d_results", 64'(n_res[3]), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jelly3_sum_tree_acc.md
# jelly3_sum_tree_acc

Pipelined, parametrised adder tree that reduces N enable-masked inputs per beat and accumulates the per-beat sums across a framed burst (s_first..s_last). One result is emitted per frame. This is the successor to the single-beat sum tree: it adds configurable radix, signed/unsigned mode, saturating or wrapping output, an overflow flag, a beat counter, and full valid/ready backpressure. It sits between per-pixel/per-tap producers and downstream statistics or normalisation logic.

## Interface
- N, 16: number of input elements per beat (≥1, any value)
- UNIT, 2: adder radix per tree level (≥2)
- SIGNED, 1: 1 = two's-complement inputs/outputs, 0 = unsigned
- SATURATE, 1: 1 = clamp result to M_DATA_BITS range, 0 = wrap
- S_DATA_BITS, 8: input element width
- M_DATA_BITS, S_DATA_BITS+$clog2(N)+8: output/accumulator width
- USER_BITS, 1: sideband width, captured from the s_last beat
- COUNT_BITS, 16: beat-counter width
- LATENCY, ceil(log_UNIT(N)) (0 when N=1): tree register stages, derived, not overridden
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cke  in  1  clock enable; 0 freezes all state
- s_en  in  N  per-element enable; disabled element contributes 0
- s_data  in  N×S_DATA_BITS  input elements
- s_first  in  1  first beat of frame; reloads accumulator
- s_last  in  1  last beat of frame; triggers output
- s_user  in  USER_BITS  sideband
- s_valid  in  1  input beat valid
- s_ready  out  1  input accepted when s_valid && s_ready
- m_data  out  M_DATA_BITS  frame sum
- m_count  out  COUNT_BITS  beats in frame (saturates at all-ones)
- m_ovf  out  1  frame overflowed M_DATA_BITS range (sticky per frame)
- m_user  out  USER_BITS  s_user of the last beat
- m_valid  out  1  result valid
- m_ready  in  1  downstream accepts result

## Operation
- advance = cke && (!m_valid || m_ready); s_ready = advance (combinational from m_ready/m_valid/cke).
- Tree: level k groups UNIT operands of level k-1, partial groups padded with 0; each level registered, advanced only on advance. Internal width S_DATA_BITS+$clog2(N), sign- or zero-extended per SIGNED; tree itself never overflows.
- valid, first, last, user travel with the data through the LATENCY stages.
- Accumulate stage (on advance, tree output valid): base = first ? 0 : acc; wide = base + tree_sum in M_DATA_BITS+1 bits; out of M_DATA_BITS range → ovf set; SATURATE=1 clamps to max/min, else wraps (low M_DATA_BITS bits). Saturated acc stays clamped on later beats of the frame.
- ovf_acc = (first ? 0 : ovf_acc) | ovf; cnt = first ? 1 : min(cnt+1, all-ones).
- On a last beat: m_data/m_ovf/m_count/m_user load, m_valid=1; acc, ovf_acc, cnt clear to 0 so a frame missing s_first starts clean. s_first && s_last = single-beat frame.
- m_valid clears when m_ready && cke with no new last beat arriving; back-to-back last beats keep m_valid high.
- Reset: all pipeline valids, m_valid, acc, cnt, ovf_acc, m_data, m_count, m_ovf, m_user → 0. Reset mid-frame discards the partial frame; no output produced for it.

## Timing
- Latency accepted s_last beat → m_valid: LATENCY+1 cycles with no stall (N=16, UNIT=2: 5).
- Throughput one beat per cycle while m_ready=1 or m_valid=0.
- m_valid && !m_ready: whole pipeline stalls, s_ready=0 same cycle; m_data etc. held stable.
- cke=0: no state changes, s_ready=0.

## Test plan
- N=16, UNIT=2, SIGNED=1, all s_en=1, s_data[i]=i, single-beat frames continuous → m_data=120, m_count=1, m_valid 5 cycles after first accept, one result/cycle.
- 3-beat frame, all elements -128, all enabled → m_data=-6144, m_count=3, m_ovf=0; random s_en per beat → m_data equals masked reference sum.
- M_DATA_BITS=12, SATURATE=1, 2 beats summing +2032 each → m_data=2047, m_ovf=1; SATURATE=0 → m_data=-32, m_ovf=1; next frame m_ovf=0.
- Continuous random input, m_ready low 10 cycles mid-stream → s_ready drops same cycle, no result lost or duplicated, order preserved vs. reference model.
- Reset asserted after 2 beats of a 4-beat frame, released, new 1-beat frame of all 1s → only one result, m_data=16, m_count=1.
- N=10, UNIT=4, SIGNED=0, s_data=255 all enabled → LATENCY=2, m_data=2550 after 3 cycles; s_en all 0 → m_data=0.
